// File: rtl/restoring_div_seq_if.sv
// Host-side handshake bundle for the sequential restoring divider.
//   start        host request, sampled by the divider only while idle
//   dividend     unsigned N, captured on the accepted start edge
//   divisor      unsigned D, captured on the accepted start edge
//   busy         divider iterating
//   done         one-cycle result-valid pulse
//   quotient     floor(N/D), all-ones on divide-by-zero
//   remainder    N mod D, N on divide-by-zero
//   div_by_zero  flags a zero divisor, held with the results
// master = host, slave = divider.
interface restoring_div_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/restoring_div_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// A WIDTH+1-bit ripple-borrow chain of full-subtractor cells forms the
// trial difference; its final borrow decides keep (trial) or restore.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    slave side of restoring_div_seq_if (start/busy/done handshake,
//          operands in, quotient/remainder/div_by_zero out)

// Single-bit full subtractor: d = a - b - bin, bout = borrow out.
module fs (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module restoring_div_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  restoring_div_seq_if.slave   bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH:0]   r;          // partial remainder, keeps the carried-out bit
  logic [WIDTH-1:0] q;          // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dreg;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             dz_r;

  logic [WIDTH:0]   s;          // shifted remainder
  logic [WIDTH:0]   sub;
  logic [WIDTH:0]   t;          // trial difference
  logic [WIDTH+1:0] bchain;
  logic             bout;
  logic [WIDTH:0]   r_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             last;
  logic             accept;
  logic             unused_r_msb;

  assign s         = {r[WIDTH-1:0], q[WIDTH-1]};
  assign sub       = {1'b0, dreg};
  assign bchain[0] = 1'b0;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_chain
    fs u_fs (
      .a    (s[i]),
      .b    (sub[i]),
      .bin  (bchain[i]),
      .d    (t[i]),
      .bout (bchain[i+1])
    );
  end

  assign bout   = bchain[WIDTH+1];
  assign r_nxt  = bout ? s : t;
  assign q_nxt  = {q[WIDTH-2:0], ~bout};
  assign last   = (cnt == CNT_W'(1));
  assign accept = (state == IDLE) && bus.start;

  // R < D after every iteration, so the top bit of R never feeds S.
  assign unused_r_msb = r[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (bus.start) state_nxt = (bus.divisor == '0) ? DONE : RUN;
      RUN:  if (last)      state_nxt = DONE;
      DONE:                state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy        = (state == RUN);
    bus.done        = (state == DONE);
    bus.quotient    = quotient_r;
    bus.remainder   = remainder_r;
    bus.div_by_zero = dz_r;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r           <= '0;
      q           <= '0;
      dreg        <= '0;
      cnt         <= '0;
      quotient_r  <= '0;
      remainder_r <= '0;
      dz_r        <= 1'b0;
    end else if (accept) begin
      if (bus.divisor == '0) begin
        quotient_r  <= '1;
        remainder_r <= bus.dividend;
        dz_r        <= 1'b1;
      end else begin
        r    <= '0;
        q    <= bus.dividend;
        dreg <= bus.divisor;
        cnt  <= CNT_W'(WIDTH);
        dz_r <= 1'b0;
      end
    end else if (state == RUN) begin
      r   <= r_nxt;
      q   <= q_nxt;
      cnt <= cnt - CNT_W'(1);
      if (last) begin
        quotient_r  <= q_nxt;
        remainder_r <= r_nxt[WIDTH-1:0];
      end
    end
  end
endmodule
